mem_port_arbiter: RTL

- Shares the single refill/writeback port of the next memory level between the L1 I-cache and the L1 D-cache.
- Sits between both cache controllers and the memory model.
- Serialises block transfers and returns each response to the requester that owns it.
- While a cache's `*_ready` is low, that cache holds its miss stall toward the pipeline hazard control.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the next-level memory port between the L1 I-cache and D-cache.
// Optional round-robin tie-break when ARB_ROUND_ROBIN_EN is defined (default: fixed D-cache priority).
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_W     = 128,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ic_req,
    input  logic [ADDR_W-1:0]  ic_addr,
    output logic [BLOCK_W-1:0] ic_rdata,
    output logic               ic_ready,
    input  logic               dc_req,
    input  logic               dc_we,
    input  logic [ADDR_W-1:0]  dc_addr,
    input  logic [BLOCK_W-1:0] dc_wdata,
    output logic [BLOCK_W-1:0] dc_rdata,
    output logic               dc_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ready,
    output logic               busy,
    output logic               timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IC = 2'd1,
        GRANT_DC = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 mem_req_reg, mem_req_next;
    logic                 mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]    mem_addr_reg, mem_addr_next;
    logic [BLOCK_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [BLOCK_W-1:0]   ic_rdata_reg, ic_rdata_next;
    logic [BLOCK_W-1:0]   dc_rdata_reg, dc_rdata_next;
    logic                 ic_ready_reg, ic_ready_next;
    logic                 dc_ready_reg, dc_ready_next;
    logic                 busy_reg, busy_next;
    logic                 timeout_err_reg, timeout_err_next;
    logic                 pick_dc;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D-cache was granted most recently; on a collision the other side wins.
    logic last_grant_reg, last_grant_next;

    always_comb begin
        pick_dc = dc_req && (!ic_req || !last_grant_reg);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_reg <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`else
    always_comb begin
        pick_dc = dc_req;
    end
`endif

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        mem_req_next     = mem_req_reg;
        mem_we_next      = mem_we_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        ic_rdata_next    = ic_rdata_reg;
        dc_rdata_next    = dc_rdata_reg;
        ic_ready_next    = 1'b0;
        dc_ready_next    = 1'b0;
        timeout_err_next = timeout_err_reg;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_next  = last_grant_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (pick_dc) begin
                    state_next     = GRANT_DC;
                    mem_req_next   = 1'b1;
                    mem_we_next    = dc_we;
                    mem_addr_next  = dc_addr;
                    mem_wdata_next = dc_wdata;
                    cnt_next       = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_next = 1'b1;
`endif
                end else if (ic_req) begin
                    state_next     = GRANT_IC;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = ic_addr;
                    mem_wdata_next = '0;
                    cnt_next       = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_next = 1'b0;
`endif
                end
            end
            GRANT_IC, GRANT_DC: begin
                // A completing mem_ready wins over a timeout landing on the same cycle.
                if (mem_ready) begin
                    state_next   = RESP;
                    mem_req_next = 1'b0;
                    if (state_reg == GRANT_DC) begin
                        dc_rdata_next = mem_rdata;
                        dc_ready_next = 1'b1;
                    end else begin
                        ic_rdata_next = mem_rdata;
                        ic_ready_next = 1'b1;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    state_next       = RESP;
                    mem_req_next     = 1'b0;
                    timeout_err_next = 1'b1;
                    cnt_next         = CNT_MAX;
                    if (state_reg == GRANT_DC) begin
                        dc_rdata_next = '0;
                        dc_ready_next = 1'b1;
                    end else begin
                        ic_rdata_next = '0;
                        ic_ready_next = 1'b1;
                    end
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            ic_rdata_reg    <= '0;
            dc_rdata_reg    <= '0;
            ic_ready_reg    <= 1'b0;
            dc_ready_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            mem_req_reg     <= mem_req_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            ic_rdata_reg    <= ic_rdata_next;
            dc_rdata_reg    <= dc_rdata_next;
            ic_ready_reg    <= ic_ready_next;
            dc_ready_reg    <= dc_ready_next;
            busy_reg        <= busy_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign mem_req     = mem_req_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign ic_rdata    = ic_rdata_reg;
    assign dc_rdata    = dc_rdata_reg;
    assign ic_ready    = ic_ready_reg;
    assign dc_ready    = dc_ready_reg;
    assign busy        = busy_reg;
    assign timeout_err = timeout_err_reg;

endmodule
